sync_fifo_prog: RTL and testbench

Single-clock FIFO for same-domain buffering, and the next generation of the team's FIFO line. Adds the following over the dual-clock part:
- programmable almost-full and almost-empty thresholds
- an occupancy count output
- sticky overflow and underflow error flags
- a selectable first-word-fall-through (FWFT) read mode

It sits between producer and consumer blocks that share one clock.

---
 rtl/fifo_pkg.sv | 13 +
 rtl/sync_fifo_prog_if.sv | 37 +++
 rtl/fifo_dpram.sv | 41 ++++
 rtl/sync_fifo_prog.sv | 125 ++++++++++++
 tb/tb_sync_fifo_prog.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: read-mode constants and pointer width helper.
// Also used by the dual-clock FIFO.
package fifo_pkg;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo_prog_if.sv
// Handshake bundle between sync_fifo_prog and its producer/consumer.
// The master side drives requests; the slave side is the FIFO itself.
interface sync_fifo_prog_if
    import fifo_pkg::*;
#(
    parameter int WIDTH = 5,
    parameter int DEPTH = 16
);
    localparam int CW = ptr_w(DEPTH);

    logic             w_en;
    logic [WIDTH-1:0] i_dat;
    logic             full;
    logic             almost_full;
    logic             r_en;
    logic [WIDTH-1:0] o_dat;
    logic             o_valid;
    logic             empty;
    logic             almost_empty;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic             clr_err;

    modport master (
        output w_en, i_dat, r_en, clr_err,
        input  full, almost_full, o_dat, o_valid, empty, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  w_en, i_dat, r_en, clr_err,
        output full, almost_full, o_dat, o_valid, empty, almost_empty,
               count, overflow, underflow
    );

endinterface

// File: rtl/fifo_dpram.sv
// WIDTH x DEPTH storage with a synchronous write port and a read port that is
// either registered (read data updates on the edge after re) or combinational.
module fifo_dpram #(
    parameter int WIDTH  = 5,
    parameter int DEPTH  = 16,
    parameter bit REG_RD = 1'b1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage write; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    if (REG_RD) begin : g_reg_rd
        // Registered read: the output word holds until the next accepted read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rdata <= '0;
            end else if (re) begin
                rdata <= mem[raddr];
            end
        end
    end else begin : g_comb_rd
        assign rdata = mem[raddr];
    end

endmodule

// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy count, sticky overflow/underflow flags and optional
// first-word-fall-through read mode.
module sync_fifo_prog
    import fifo_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int DEPTH    = 16,
    parameter int FWFT     = FIFO_STD,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2
) (
    input logic             clk,
    input logic             rst,
    sync_fifo_prog_if.slave bus
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = ptr_w(DEPTH);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $fatal(1, "sync_fifo_prog: DEPTH must be a power of 2 and at least 4");
    end
    if (!(AE_LEVEL > 0 && AE_LEVEL < AF_LEVEL && AF_LEVEL <= DEPTH)) begin : g_bad_levels
        $fatal(1, "sync_fifo_prog: need 0 < AE_LEVEL < AF_LEVEL <= DEPTH");
    end
    if (FWFT != FIFO_STD && FWFT != FIFO_FWFT) begin : g_bad_mode
        $fatal(1, "sync_fifo_prog: FWFT must be 0 or 1");
    end

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW-1:0] cnt;
    logic          full_i;
    logic          empty_i;
    logic          w_acc;
    logic          r_acc;
    logic          ovf_q;
    logic          unf_q;

    // Wrap bit distinguishes full from empty when the address bits match.
    assign full_i  = (wptr[PW-1] != rptr[PW-1]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty_i = (wptr == rptr);

    // A full FIFO refuses writes and an empty one refuses reads, regardless of
    // what the other port does in the same cycle.
    assign w_acc = bus.w_en & ~full_i;
    assign r_acc = bus.r_en & ~empty_i;

    // Pointer advance on accepted transfers; natural roll-over modulo 2*DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (w_acc) wptr <= wptr + PW'(1);
            if (r_acc) rptr <= rptr + PW'(1);
        end
    end

    // Occupancy tracks accepted writes minus accepted reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case ({w_acc, r_acc})
                2'b10:   cnt <= cnt + PW'(1);
                2'b01:   cnt <= cnt - PW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    // Sticky error flags; a new error takes priority over a clear request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (bus.w_en && full_i)  ovf_q <= 1'b1;
            else if (bus.clr_err)    ovf_q <= 1'b0;
            if (bus.r_en && empty_i) unf_q <= 1'b1;
            else if (bus.clr_err)    unf_q <= 1'b0;
        end
    end

    fifo_dpram #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .REG_RD (FWFT == FIFO_STD)
    ) u_mem (
        .clk    (clk),
        .rst    (rst),
        .we     (w_acc),
        .waddr  (wptr[AW-1:0]),
        .wdata  (bus.i_dat),
        .re     (r_acc),
        .raddr  (rptr[AW-1:0]),
        .rdata  (bus.o_dat)
    );

    if (FWFT == FIFO_FWFT) begin : g_fwft_valid
        assign bus.o_valid = ~empty_i;
    end else begin : g_std_valid
        logic valid_q;
        // In registered mode o_valid marks the cycle after an accepted pop.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                valid_q <= 1'b0;
            end else begin
                valid_q <= r_acc;
            end
        end
        assign bus.o_valid = valid_q;
    end

    assign bus.full         = full_i;
    assign bus.empty        = empty_i;
    assign bus.count        = cnt;
    assign bus.almost_full  = (cnt >= PW'(AF_LEVEL));
    assign bus.almost_empty = (cnt <= PW'(AE_LEVEL));
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Self-checking bench for sync_fifo_prog: a standard-mode instance exercised
// through a queue scoreboard, plus a FWFT instance.
module tb_sync_fifo_prog;
    import fifo_pkg::*;

    localparam int WIDTH = 5;
    localparam int DEPTH = 16;
    localparam int AFL   = 14;
    localparam int AEL   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_fifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) b0 ();
    sync_fifo_prog_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) b1 ();

    sync_fifo_prog #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(FIFO_STD), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) u_std (
        .clk (clk),
        .rst (rst),
        .bus (b0)
    );

    sync_fifo_prog #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .FWFT(FIFO_FWFT), .AF_LEVEL(AFL), .AE_LEVEL(AEL)
    ) u_fwft (
        .clk (clk),
        .rst (rst),
        .bus (b1)
    );

    int errors = 0;
    int checks = 0;

    logic [WIDTH-1:0] mdl[$];
    logic [WIDTH-1:0] exp_od;
    logic             exp_ov;
    logic             exp_ovf;
    logic             exp_unf;

    task automatic model_reset();
        mdl.delete();
        exp_od  = '0;
        exp_ov  = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
    endtask

    // One clock on the standard instance: predict, clock, compare everything.
    task automatic step(input logic we, input logic [WIDTH-1:0] wd, input logic re,
                        input logic clr, input string tag);
        logic rd;
        logic wr;
        int   n;
        b0.w_en    = we;
        b0.i_dat   = wd;
        b0.r_en    = re;
        b0.clr_err = clr;
        n  = mdl.size();
        rd = re && (n != 0);
        wr = we && (n != DEPTH);
        if (we && n == DEPTH) exp_ovf = 1'b1;
        else if (clr)         exp_ovf = 1'b0;
        if (re && n == 0)     exp_unf = 1'b1;
        else if (clr)         exp_unf = 1'b0;
        exp_ov = rd;
        if (rd) exp_od = mdl.pop_front();
        if (wr) mdl.push_back(wd);
        @(posedge clk);
        #1;
        n = mdl.size();
        checks += 9;
        if (b0.count !== 5'(n)) begin
            errors++; $display("FAIL %s count: got %0d want %0d", tag, b0.count, n);
        end
        if (b0.full !== (n == DEPTH)) begin
            errors++; $display("FAIL %s full: got %0b want %0b", tag, b0.full, n == DEPTH);
        end
        if (b0.empty !== (n == 0)) begin
            errors++; $display("FAIL %s empty: got %0b want %0b", tag, b0.empty, n == 0);
        end
        if (b0.almost_full !== (n >= AFL)) begin
            errors++; $display("FAIL %s almost_full: got %0b want %0b", tag, b0.almost_full, n >= AFL);
        end
        if (b0.almost_empty !== (n <= AEL)) begin
            errors++; $display("FAIL %s almost_empty: got %0b want %0b", tag, b0.almost_empty, n <= AEL);
        end
        if (b0.overflow !== exp_ovf) begin
            errors++; $display("FAIL %s overflow: got %0b want %0b", tag, b0.overflow, exp_ovf);
        end
        if (b0.underflow !== exp_unf) begin
            errors++; $display("FAIL %s underflow: got %0b want %0b", tag, b0.underflow, exp_unf);
        end
        if (b0.o_valid !== exp_ov) begin
            errors++; $display("FAIL %s o_valid: got %0b want %0b", tag, b0.o_valid, exp_ov);
        end
        if (b0.o_dat !== exp_od) begin
            errors++; $display("FAIL %s o_dat: got %0d want %0d", tag, b0.o_dat, exp_od);
        end
    endtask

    task automatic idle_inputs();
        b0.w_en = 0; b0.i_dat = '0; b0.r_en = 0; b0.clr_err = 0;
        b1.w_en = 0; b1.i_dat = '0; b1.r_en = 0; b1.clr_err = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks += 12;
        if (b0.count !== 5'd0)      begin errors++; $display("FAIL rst count: got %0d want 0", b0.count); end
        if (b0.empty !== 1'b1)      begin errors++; $display("FAIL rst empty: got %0b want 1", b0.empty); end
        if (b0.full !== 1'b0)       begin errors++; $display("FAIL rst full: got %0b want 0", b0.full); end
        if (b0.almost_full !== 1'b0)  begin errors++; $display("FAIL rst almost_full: got %0b want 0", b0.almost_full); end
        if (b0.almost_empty !== 1'b1) begin errors++; $display("FAIL rst almost_empty: got %0b want 1", b0.almost_empty); end
        if (b0.overflow !== 1'b0)   begin errors++; $display("FAIL rst overflow: got %0b want 0", b0.overflow); end
        if (b0.underflow !== 1'b0)  begin errors++; $display("FAIL rst underflow: got %0b want 0", b0.underflow); end
        if (b0.o_valid !== 1'b0)    begin errors++; $display("FAIL rst o_valid: got %0b want 0", b0.o_valid); end
        if (b0.o_dat !== 5'd0)      begin errors++; $display("FAIL rst o_dat: got %0d want 0", b0.o_dat); end
        if (b1.empty !== 1'b1)      begin errors++; $display("FAIL rst fwft empty: got %0b want 1", b1.empty); end
        if (b1.o_valid !== 1'b0)    begin errors++; $display("FAIL rst fwft o_valid: got %0b want 0", b1.o_valid); end
        if (b1.count !== 5'd0)      begin errors++; $display("FAIL rst fwft count: got %0d want 0", b1.count); end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_overfill();
        for (int i = 0; i < 21; i++) begin
            step(1'b1, 5'(7 + i), 1'b0, 1'b0, "overfill_wr");
            if (i == 15) begin
                checks++;
                if (b0.full !== 1'b1 || b0.count !== 5'd16) begin
                    errors++;
                    $display("FAIL full_after_16: got full=%0b count=%0d want full=1 count=16", b0.full, b0.count);
                end
            end
        end
        checks++;
        if (b0.overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b want 1", b0.overflow); end
        for (int i = 0; i < 21; i++) step(1'b0, '0, 1'b1, 1'b0, "overdrain_rd");
        checks += 3;
        if (b0.o_dat !== 5'd22)    begin errors++; $display("FAIL o_dat_hold: got %0d want 22", b0.o_dat); end
        if (b0.underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %0b want 1", b0.underflow); end
        if (b0.empty !== 1'b1 || b0.count !== 5'd0) begin
            errors++; $display("FAIL drained: got empty=%0b count=%0d want 1/0", b0.empty, b0.count);
        end
        step(1'b0, '0, 1'b0, 1'b1, "clr_err");
        checks++;
        if (b0.overflow !== 1'b0 || b0.underflow !== 1'b0) begin
            errors++; $display("FAIL clr_err: got ovf=%0b unf=%0b want 0/0", b0.overflow, b0.underflow);
        end
        step(1'b0, '0, 1'b0, 1'b0, "idle");
    endtask

    task automatic test_thresholds();
        for (int i = 1; i <= 14; i++) begin
            step(1'b1, 5'(i), 1'b0, 1'b0, "thr_wr");
            if (i == 2 || i == 3) begin
                checks++;
                if (b0.almost_empty !== (i == 2)) begin
                    errors++; $display("FAIL ae_after_wr%0d: got %0b want %0b", i, b0.almost_empty, i == 2);
                end
            end
            if (i == 13 || i == 14) begin
                checks++;
                if (b0.almost_full !== (i == 14)) begin
                    errors++; $display("FAIL af_after_wr%0d: got %0b want %0b", i, b0.almost_full, i == 14);
                end
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, '0, 1'b1, 1'b0, "thr_rd");
        checks++;
        if (b0.almost_empty !== 1'b1 || b0.count !== 5'd2) begin
            errors++; $display("FAIL ae_back_at_2: got ae=%0b count=%0d want 1/2", b0.almost_empty, b0.count);
        end
        for (int i = 0; i < 2; i++) step(1'b0, '0, 1'b1, 1'b0, "thr_rd");
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 3), 1'b0, 1'b0, "sim_fill8");
        for (int i = 0; i < 4; i++) step(1'b1, 5'(i + 20), 1'b1, 1'b0, "sim_both8");
        checks++;
        if (b0.count !== 5'd8) begin errors++; $display("FAIL both_at_8: got count %0d want 8", b0.count); end
        for (int i = 0; i < 8; i++) step(1'b1, 5'(i + 24), 1'b0, 1'b0, "sim_fill16");
        step(1'b1, 5'd31, 1'b1, 1'b1, "sim_both16");
        checks++;
        if (b0.count !== 5'd15 || b0.overflow !== 1'b1) begin
            errors++; $display("FAIL both_at_16: got count=%0d ovf=%0b want 15/1", b0.count, b0.overflow);
        end
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, 1'b0, "sim_drain");
        step(1'b0, '0, 1'b0, 1'b1, "sim_clr");
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 10; i++) step(1'b1, 5'(i + 20), 1'b0, 1'b0, "wrap_wr10");
        for (int i = 0; i < 10; i++) step(1'b0, '0, 1'b1, 1'b0, "wrap_rd10");
        for (int i = 1; i <= 16; i++) step(1'b1, 5'(i), 1'b0, 1'b0, "wrap_wr16");
        checks++;
        if (b0.full !== 1'b1) begin errors++; $display("FAIL wrap_full: got %0b want 1", b0.full); end
        for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b1, 1'b0, "wrap_rd16");
        step(1'b0, '0, 1'b0, 1'b0, "idle");
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 9; i++) step(1'b1, 5'(i + 1), 1'b0, 1'b0, "ar_wr");
        b0.w_en  = 1'b1;
        b0.i_dat = 5'd30;
        #3;
        rst = 1'b1;
        #1;
        checks += 6;
        if (b0.count !== 5'd0)   begin errors++; $display("FAIL async_rst count: got %0d want 0", b0.count); end
        if (b0.empty !== 1'b1)   begin errors++; $display("FAIL async_rst empty: got %0b want 1", b0.empty); end
        if (b0.full !== 1'b0)    begin errors++; $display("FAIL async_rst full: got %0b want 0", b0.full); end
        if (b0.almost_empty !== 1'b1) begin errors++; $display("FAIL async_rst almost_empty: got %0b want 1", b0.almost_empty); end
        if (b0.o_valid !== 1'b0) begin errors++; $display("FAIL async_rst o_valid: got %0b want 0", b0.o_valid); end
        if (b0.o_dat !== 5'd0)   begin errors++; $display("FAIL async_rst o_dat: got %0d want 0", b0.o_dat); end
        idle_inputs();
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        step(1'b0, '0, 1'b0, 1'b0, "post_rst");
    endtask

    task automatic test_fwft();
        logic [WIDTH-1:0] fq[$];
        logic [WIDTH-1:0] e;
        b1.w_en  = 1'b1;
        b1.i_dat = 5'h05;
        @(posedge clk);
        #1;
        b1.w_en = 1'b0;
        checks += 3;
        if (b1.empty !== 1'b0)   begin errors++; $display("FAIL fwft empty: got %0b want 0", b1.empty); end
        if (b1.o_valid !== 1'b1) begin errors++; $display("FAIL fwft o_valid: got %0b want 1", b1.o_valid); end
        if (b1.o_dat !== 5'h05)  begin errors++; $display("FAIL fwft o_dat: got %0h want 05", b1.o_dat); end
        b1.r_en = 1'b1;
        @(posedge clk);
        #1;
        b1.r_en = 1'b0;
        checks += 2;
        if (b1.empty !== 1'b1)   begin errors++; $display("FAIL fwft pop empty: got %0b want 1", b1.empty); end
        if (b1.o_valid !== 1'b0) begin errors++; $display("FAIL fwft pop o_valid: got %0b want 0", b1.o_valid); end
        for (int i = 0; i < 3; i++) begin
            b1.w_en  = 1'b1;
            b1.i_dat = 5'(9 + 3 * i);
            fq.push_back(5'(9 + 3 * i));
            @(posedge clk);
            #1;
        end
        b1.w_en = 1'b0;
        while (fq.size() != 0) begin
            e = fq.pop_front();
            checks += 2;
            if (b1.o_valid !== 1'b1) begin errors++; $display("FAIL fwft head valid: got %0b want 1", b1.o_valid); end
            if (b1.o_dat !== e) begin errors++; $display("FAIL fwft head: got %0d want %0d", b1.o_dat, e); end
            b1.r_en = 1'b1;
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        b1.r_en = 1'b0;
        checks += 2;
        if (b1.empty !== 1'b1)     begin errors++; $display("FAIL fwft end empty: got %0b want 1", b1.empty); end
        if (b1.underflow !== 1'b1) begin errors++; $display("FAIL fwft underflow: got %0b want 1", b1.underflow); end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_overfill();
        test_thresholds();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        test_fwft();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
